input_debounce: RTL and testbench



---
 rtl/io_pkg.sv | 37 +++
 rtl/debounce_bit.sv | 98 +++++++++
 rtl/input_debounce.sv | 73 +++++++
 tb/tb_input_debounce.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : io_pkg
//  Purpose : Shared constants for the board input conditioning path.
//            Channel indices follow the PORTI/PORTJ bit layout seen by comp:
//            bits 0-4 are push buttons, bits 5-20 are slide switches.
//  Rev     : 1.0  initial release
// ============================================================================
package io_pkg;

  localparam int DEF_WIDTH        = 21;
  localparam int DEF_STABLE_TICKS = 4;
  localparam int DEF_CNT_W        = 3;

  // Push buttons
  localparam int IDX_BTNC = 0;
  localparam int IDX_BTND = 1;
  localparam int IDX_BTNU = 2;
  localparam int IDX_BTNR = 3;
  localparam int IDX_BTNL = 4;

  // Slide switches SW0..SW15 occupy bits 5..20
  localparam int IDX_SW0  = 5;
  localparam int IDX_SW15 = 20;

  // Channel class, handy when mapping a bit index back to the board.
  typedef enum logic [0:0] {
    CH_BUTTON = 1'b0,
    CH_SWITCH = 1'b1
  } ch_kind_e;

  function automatic ch_kind_e ch_kind(input int idx);
    return (idx >= IDX_SW0) ? CH_SWITCH : CH_BUTTON;
  endfunction

endpackage : io_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module  : debounce_bit
//  Purpose : One input channel: 2-flop synchronizer, tick-paced debounce
//            counter, debounced level, one-cycle edge pulses and a sticky
//            press flag with level-sensitive clear.
//  Ports   : clk, rst        - system clock, synchronous active-high reset
//            i_tick          - sample strobe (one clk wide)
//            i_din           - raw asynchronous pin level
//            i_clr           - clear for o_latch
//            o_dout          - debounced level
//            o_rise/o_fall   - registered one-cycle edge pulses
//            o_latch         - sticky flag set by a rise
//            o_rise_next/o_fall_next - values o_rise/o_fall take on the
//                              next edge (lets the parent register CHANGED
//                              in step with the pulses)
//  Rev     : 1.0  initial release
// ============================================================================
module debounce_bit
  import io_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_din,
  input  logic i_clr,
  output logic o_dout,
  output logic o_rise,
  output logic o_fall,
  output logic o_latch,
  output logic o_rise_next,
  output logic o_fall_next
);

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(STABLE_TICKS - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dout;
  logic             r_dout_d;
  logic             r_rise;
  logic             r_fall;
  logic             r_latch;

  // The pulses trail the accepting edge by one clock: they are derived from
  // the debounced level and its one-cycle-delayed copy.
  logic w_rise_next;
  logic w_fall_next;

  assign w_rise_next =  r_dout & ~r_dout_d;
  assign w_fall_next = ~r_dout &  r_dout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_cnt    <= '0;
      r_dout   <= 1'b0;
      r_dout_d <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_latch  <= 1'b0;
    end else begin
      r_s1     <= i_din;
      r_s2     <= r_s1;
      r_dout_d <= r_dout;
      r_rise   <= w_rise_next;
      r_fall   <= w_fall_next;
      // A set arriving together with a clear wins.
      r_latch  <= (r_latch & ~i_clr) | w_rise_next;

      if (i_tick) begin
        if (r_s2 == r_dout) begin
          // Any sample back at the current level restarts the count.
          r_cnt <= '0;
        end else if (r_cnt == c_last_cnt) begin
          r_dout <= r_s2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_dout      = r_dout;
  assign o_rise      = r_rise;
  assign o_fall      = r_fall;
  assign o_latch     = r_latch;
  assign o_rise_next = w_rise_next;
  assign o_fall_next = w_fall_next;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : input_debounce
//  Purpose : Conditions the raw board buttons and switches before they reach
//            comp's PORTI/PORTJ. One debounce_bit per channel, plus a common
//            CHANGED flag that pulses whenever any channel emits RISE or FALL.
//  Ports   : CLK, RESET - system clock, synchronous active-high reset
//            TICK       - 1 kHz sample strobe, one CLK wide
//            DIN        - raw pin levels
//            CLR        - per-bit clear of LATCH
//            DOUT       - debounced levels
//            RISE/FALL  - one-CLK edge pulses
//            LATCH      - sticky press flags
//            CHANGED    - OR of RISE|FALL, aligned with them
//  Note    : CNT_W must satisfy 2**CNT_W > STABLE_TICKS, STABLE_TICKS >= 1.
//  Rev     : 1.0  initial release
// ============================================================================
module input_debounce
  import io_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TICK,
  input  logic [WIDTH-1:0] DIN,
  input  logic [WIDTH-1:0] CLR,
  output logic [WIDTH-1:0] DOUT,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic [WIDTH-1:0] LATCH,
  output logic             CHANGED
);

  logic [WIDTH-1:0] w_rise_next;
  logic [WIDTH-1:0] w_fall_next;
  logic             r_changed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_bit #(
      .STABLE_TICKS (STABLE_TICKS),
      .CNT_W        (CNT_W)
    ) u_bit (
      .clk         (CLK),
      .rst         (RESET),
      .i_tick      (TICK),
      .i_din       (DIN[i]),
      .i_clr       (CLR[i]),
      .o_dout      (DOUT[i]),
      .o_rise      (RISE[i]),
      .o_fall      (FALL[i]),
      .o_latch     (LATCH[i]),
      .o_rise_next (w_rise_next[i]),
      .o_fall_next (w_fall_next[i])
    );
  end

  // Built from the per-channel next-values so it lands on the same edge as
  // the RISE/FALL pulses rather than one clock later.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |(w_rise_next | w_fall_next);
    end
  end

  assign CHANGED = r_changed;

endmodule : input_debounce
`default_nettype wire

// File: tb/tb_input_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : tb_input_debounce
//  Purpose : Self-checking bench. Two DUT instances (STABLE_TICKS=4 and 1)
//            share DIN/CLR/RESET with separate tick strobes. A behavioural
//            model keeps the last tick samples per channel and accepts a new
//            level once the most recent STABLE_TICKS samples all disagree
//            with the current level.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_input_debounce;
  import io_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick = 1'b0;
  logic         tick1 = 1'b1;
  logic [W-1:0] din = '0;
  logic [W-1:0] clr = '0;

  logic [W-1:0] dout0, rise0, fall0, latch0;
  logic         chg0;
  logic [W-1:0] dout1, rise1, fall1, latch1;
  logic         chg1;

  always #5 clk = ~clk;

  input_debounce #(.WIDTH(W), .STABLE_TICKS(4), .CNT_W(3)) dut0 (
    .CLK(clk), .RESET(rst), .TICK(tick), .DIN(din), .CLR(clr),
    .DOUT(dout0), .RISE(rise0), .FALL(fall0), .LATCH(latch0), .CHANGED(chg0)
  );

  input_debounce #(.WIDTH(W), .STABLE_TICKS(1), .CNT_W(1)) dut1 (
    .CLK(clk), .RESET(rst), .TICK(tick1), .DIN(din), .CLR(clr),
    .DOUT(dout1), .RISE(rise1), .FALL(fall1), .LATCH(latch1), .CHANGED(chg1)
  );

  int ntest = 0;
  int nerr  = 0;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    ntest++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_s1[2], m_s2[2], m_dout[2], m_acr[2], m_acf[2];
  logic [W-1:0] m_rise[2], m_fall[2], m_latch[2];
  logic         m_chg[2];
  logic         m_valid[2] = '{1'b0, 1'b0};
  logic [31:0]  hist[2][W];
  int           nval[2][W];

  task automatic step(input int k, input int st, input logic r,
                      input logic [W-1:0] d, input logic [W-1:0] c, input logic t);
    logic [W-1:0] nr, nf;
    logic [31:0]  mask;
    if (r) begin
      m_s1[k] = '0; m_s2[k] = '0; m_dout[k] = '0; m_acr[k] = '0; m_acf[k] = '0;
      m_rise[k] = '0; m_fall[k] = '0; m_latch[k] = '0; m_chg[k] = 1'b0;
      for (int i = 0; i < W; i++) begin
        hist[k][i] = '0;
        nval[k][i] = 0;
      end
      m_valid[k] = 1'b1;
    end else begin
      m_rise[k]  = m_acr[k];
      m_fall[k]  = m_acf[k];
      m_chg[k]   = |(m_acr[k] | m_acf[k]);
      m_latch[k] = (m_latch[k] & ~c) | m_acr[k];
      nr = '0;
      nf = '0;
      mask = (32'd1 << st) - 32'd1;
      if (t) begin
        for (int i = 0; i < W; i++) begin
          hist[k][i] = {hist[k][i][30:0], m_s2[k][i]};
          if (nval[k][i] < 32) nval[k][i]++;
          if (nval[k][i] >= st &&
              (hist[k][i] & mask) == (m_dout[k][i] ? 32'd0 : mask)) begin
            m_dout[k][i] = ~m_dout[k][i];
            if (m_dout[k][i]) nr[i] = 1'b1;
            else              nf[i] = 1'b1;
            nval[k][i] = 0;
          end
        end
      end
      m_acr[k] = nr;
      m_acf[k] = nf;
      m_s2[k]  = m_s1[k];
      m_s1[k]  = d;
    end
  endtask

  // Snapshot inputs at the edge, evaluate model, compare after outputs settle.
  initial begin
    logic         s_rst, s_t0, s_t1;
    logic [W-1:0] s_din, s_clr;
    forever begin
      @(posedge clk);
      s_rst = rst; s_din = din; s_clr = clr; s_t0 = tick; s_t1 = tick1;
      #3;
      step(0, 4, s_rst, s_din, s_clr, s_t0);
      step(1, 1, s_rst, s_din, s_clr, s_t1);
      if (m_valid[0]) begin
        chk("m0_dout",  dout0,  m_dout[0]);
        chk("m0_rise",  rise0,  m_rise[0]);
        chk("m0_fall",  fall0,  m_fall[0]);
        chk("m0_latch", latch0, m_latch[0]);
        chk("m0_chg",   W'(chg0), W'(m_chg[0]));
      end
      if (m_valid[1]) begin
        chk("m1_dout",  dout1,  m_dout[1]);
        chk("m1_rise",  rise1,  m_rise[1]);
        chk("m1_fall",  fall1,  m_fall[1]);
        chk("m1_latch", latch1, m_latch[1]);
        chk("m1_chg",   W'(chg1), W'(m_chg[1]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
  endtask

  // One block = 10 clocks with the tick on the 5th; DIN set before a block
  // is the sample that block's tick sees.
  task automatic ticks(input int n);
    repeat (n) for (int e = 1; e <= 10; e++) cyc(e == 5);
  endtask

  initial begin
    int tk, found_tk;
    logic found_t, t;
    logic [W-1:0] flip;

    rst = 1'b1;
    repeat (3) cyc(1'b0);
    rst = 1'b0;
    chk("reset_dout", dout0, '0);
    chk("reset_latch", latch0, '0);

    // Idle: 200 clocks with DIN=0
    ticks(20);
    chk("idle_dout", dout0, '0);
    chk("idle_latch", latch0, '0);
    chk("idle_chg", W'(chg0), '0);

    // Step DIN[0] high; count ticks seen after the synchronizer has caught up.
    din = W'(1);
    tk = 0; found_tk = -1; found_t = 1'b0;
    for (int e = 1; e <= 100 && found_tk < 0; e++) begin
      t = ((e % 10) == 5);
      cyc(t);
      if (e >= 3 && t) tk++;
      if (dout0[IDX_BTNC]) begin
        found_tk = tk;
        found_t  = t;
      end
    end
    chk("rise_accept_tick", W'(found_tk), W'(4));
    chk("rise_on_tick", W'(found_t), W'(1));
    chk("rise_not_yet", rise0, '0);
    cyc(1'b0);
    chk("rise_pulse", rise0, W'(1));
    chk("rise_chg", W'(chg0), W'(1));
    chk("rise_latch", latch0, W'(1));
    cyc(1'b0);
    chk("rise_gone", rise0, '0);
    chk("latch_hold", latch0, W'(1));

    // Bounce on BTNU: 1,0,1 then held
    din[IDX_BTNU] = 1'b1; ticks(1);
    din[IDX_BTNU] = 1'b0; ticks(1);
    din[IDX_BTNU] = 1'b1; ticks(3);
    chk("bounce_wait", W'(dout0[IDX_BTNU]), W'(0));
    ticks(1);
    chk("bounce_accept", W'(dout0[IDX_BTNU]), W'(1));

    // Release BTNC
    din[IDX_BTNC] = 1'b0; ticks(4);
    chk("release_dout", W'(dout0[IDX_BTNC]), W'(0));
    chk("release_latch", W'(latch0[IDX_BTNC]), W'(1));
    clr[IDX_BTNC] = 1'b1; cyc(1'b0); clr = '0;
    chk("clr_latch", W'(latch0[IDX_BTNC]), W'(0));

    // Clear arriving on the same edge as the rise on BTND: set wins
    din[IDX_BTND] = 1'b1; ticks(3);
    repeat (4) cyc(1'b0);
    cyc(1'b1);
    chk("sim_dout", W'(dout0[IDX_BTND]), W'(1));
    clr[IDX_BTND] = 1'b1;
    cyc(1'b0);
    chk("sim_rise", W'(rise0[IDX_BTND]), W'(1));
    chk("sim_latch_set", W'(latch0[IDX_BTND]), W'(1));
    cyc(1'b0);
    chk("sim_latch_clr", W'(latch0[IDX_BTND]), W'(0));
    clr = '0;

    // All switches at once (BTND/BTNU fall in the same cycle)
    din = 21'h1FFFE0; ticks(3);
    repeat (4) cyc(1'b0);
    cyc(1'b1);
    chk("sw_dout", W'(dout0[IDX_SW15:IDX_SW0]), W'(16'hFFFF));
    cyc(1'b0);
    chk("sw_rise", W'(rise0[IDX_SW15:IDX_SW0]), W'(16'hFFFF));
    chk("sw_fall", W'(fall0[2:1]), W'(2'b11));
    chk("sw_chg", W'(chg0), W'(1));

    // Reset in the middle of a pending rise
    din = '0; ticks(5);
    din[IDX_BTNL] = 1'b1; ticks(3);
    rst = 1'b1; cyc(1'b0); cyc(1'b0); rst = 1'b0;
    chk("rst_mid_dout", dout0, '0);
    ticks(3);
    chk("rst_fresh_wait", W'(dout0[IDX_BTNL]), W'(0));
    ticks(1);
    chk("rst_fresh_accept", W'(dout0[IDX_BTNL]), W'(1));

    // STABLE_TICKS=1 with tick every clock: 2 sync + 1
    tick1 = 1'b1;
    din[IDX_BTNR] = 1'b1;
    cyc(1'b0); chk("st1_e1", W'(dout1[IDX_BTNR]), W'(0));
    cyc(1'b0); chk("st1_e2", W'(dout1[IDX_BTNR]), W'(0));
    cyc(1'b0); chk("st1_e3", W'(dout1[IDX_BTNR]), W'(1));
    cyc(1'b0); chk("st1_rise", W'(rise1[IDX_BTNR]), W'(1));

    // Randomized phase, checked by the model
    for (int n = 0; n < 4000; n++) begin
      flip = '0;
      for (int i = 0; i < W; i++) flip[i] = ($urandom_range(0, 39) == 0);
      din   = din ^ flip;
      clr   = '0;
      for (int i = 0; i < W; i++) clr[i] = ($urandom_range(0, 15) == 0);
      rst   = ($urandom_range(0, 799) == 0);
      tick1 = ($urandom_range(0, 1) == 1);
      cyc($urandom_range(0, 2) == 0);
    end
    rst = 1'b0;
    clr = '0;
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", ntest, nerr);
    $finish;
  end

endmodule : tb_input_debounce
`default_nettype wire
